// File: rtl/exc_int_ctrl_if.sv
// Exception/interrupt controller bus: core-side strobes and PCs in,
// PC redirection and architectural status (epc, cause, mask, ...) out.
interface exc_int_ctrl_if #(
  parameter int N_IRQ = 4
);
  logic [N_IRQ-1:0] irq;
  logic             exc_pc;
  logic             exc_alu;
  logic [31:0]      pc_cur;
  logic [31:0]      pc_next;
  logic             eret;
  logic             mask_wr;
  logic [N_IRQ-1:0] mask_wdata;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [31:0]      epc;
  logic [3:0]       cause;
  logic             kernel;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] pending;

  // Core / testbench side
  modport master (
    output irq, exc_pc, exc_alu, pc_cur, pc_next, eret, mask_wr, mask_wdata,
    input  redirect, redirect_pc, epc, cause, kernel, mask, pending
  );

  // Controller side
  modport slave (
    input  irq, exc_pc, exc_alu, pc_cur, pc_next, eret, mask_wr, mask_wdata,
    output redirect, redirect_pc, epc, cause, kernel, mask, pending
  );
endinterface

// File: rtl/exc_int_ctrl.sv
// Exception / interrupt controller. Two-state (USER/KERNEL) machine that
// redirects the PC in the same cycle an exception, interrupt or return is
// taken, and records epc/cause on the following clock edge.
module exc_int_ctrl #(
  parameter int          N_IRQ      = 4,
  parameter logic [31:0] EXC_VECTOR = 32'h80000008,
  parameter logic [31:0] IRQ_BASE   = 32'h80000010
) (
  input  logic         clk,
  input  logic         reset,
  exc_int_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    ST_USER   = 1'b0,
    ST_KERNEL = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [31:0]      epc_r;
  logic [31:0]      epc_nxt_s;
  logic [3:0]       cause_r;
  logic [3:0]       cause_nxt_s;
  logic [N_IRQ-1:0] mask_r;
  logic [N_IRQ-1:0] pending_r;
  logic [N_IRQ-1:0] irq_q_r;

  logic [N_IRQ-1:0] rise_s;
  logic [N_IRQ-1:0] hit_s;
  logic [N_IRQ-1:0] clr_s;
  logic [N_IRQ-1:0] pending_nxt_s;
  logic [2:0]       irq_idx_s;
  logic             irq_any_s;
  logic             illegal_s;
  logic             take_exc_s;
  logic             take_irq_s;
  logic             take_ret_s;
  logic [3:0]       exc_code_s;
  logic             redirect_s;
  logic [31:0]      redirect_pc_s;

  assign rise_s    = bus.irq & ~irq_q_r;
  assign hit_s     = pending_r & mask_r;
  // User code stepping from user space into kernel space is illegal.
  assign illegal_s = (state_r == ST_USER) && !bus.pc_cur[31] && bus.pc_next[31];
  // Every take is gated by reset so nothing redirects while reset is held.
  assign take_exc_s = reset && (bus.exc_pc || bus.exc_alu || illegal_s);
  assign take_irq_s = reset && !take_exc_s && (state_r == ST_USER) && irq_any_s;
  assign take_ret_s = reset && !take_exc_s && (state_r == ST_KERNEL) && bus.eret;

  // Lowest-index enabled pending interrupt wins.
  always_comb begin
    irq_idx_s = 3'd0;
    irq_any_s = 1'b0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (hit_s[k]) begin
        irq_idx_s = 3'(k);
        irq_any_s = 1'b1;
      end else begin
        irq_any_s = irq_any_s;
      end
    end
  end

  // Exception cause priority: illegal > PC overflow > ALU overflow.
  always_comb begin
    exc_code_s = 4'd0;
    if (illegal_s) begin
      exc_code_s = 4'd1;
    end else if (bus.exc_pc) begin
      exc_code_s = 4'd2;
    end else if (bus.exc_alu) begin
      exc_code_s = 4'd3;
    end else begin
      exc_code_s = 4'd0;
    end
  end

  // Next-state, redirect and epc/cause update decisions.
  always_comb begin
    state_nxt_s   = state_r;
    epc_nxt_s     = epc_r;
    cause_nxt_s   = cause_r;
    redirect_s    = 1'b0;
    redirect_pc_s = bus.pc_next;
    if (take_exc_s) begin
      redirect_s    = 1'b1;
      redirect_pc_s = EXC_VECTOR;
      cause_nxt_s   = exc_code_s;
      state_nxt_s   = ST_KERNEL;
      // A nested exception keeps the original return address.
      if (state_r == ST_USER) begin
        epc_nxt_s = bus.pc_cur;
      end else begin
        epc_nxt_s = epc_r;
      end
    end else if (take_irq_s) begin
      redirect_s    = 1'b1;
      redirect_pc_s = IRQ_BASE + {27'd0, irq_idx_s, 2'b00};
      epc_nxt_s     = bus.pc_next;
      cause_nxt_s   = 4'd8 + {1'b0, irq_idx_s};
      state_nxt_s   = ST_KERNEL;
    end else if (take_ret_s) begin
      redirect_s    = 1'b1;
      redirect_pc_s = epc_r;
      cause_nxt_s   = 4'd0;
      state_nxt_s   = ST_USER;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Clear the taken interrupt; a new rising edge in the same cycle wins.
  always_comb begin
    clr_s = '0;
    for (int k = 0; k < N_IRQ; k++) begin
      clr_s[k] = take_irq_s && (irq_idx_s == 3'(k));
    end
    pending_nxt_s = (pending_r & ~clr_s) | rise_s;
  end

  // State, status and interrupt bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_USER;
      epc_r     <= 32'd0;
      cause_r   <= 4'd0;
      mask_r    <= '1;
      pending_r <= '0;
      irq_q_r   <= '0;
    end else begin
      state_r   <= state_nxt_s;
      epc_r     <= epc_nxt_s;
      cause_r   <= cause_nxt_s;
      pending_r <= pending_nxt_s;
      irq_q_r   <= bus.irq;
      if (bus.mask_wr) begin
        mask_r <= bus.mask_wdata;
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  assign bus.redirect    = redirect_s;
  assign bus.redirect_pc = redirect_pc_s;
  assign bus.epc         = epc_r;
  assign bus.cause       = cause_r;
  assign bus.kernel      = (state_r == ST_KERNEL);
  assign bus.mask        = mask_r;
  assign bus.pending     = pending_r;

endmodule

// File: tb/tb_exc_int_ctrl.sv
// Directed scoreboard bench for exc_int_ctrl: the driver applies one vector
// per cycle after the rising edge and queues the expected outputs; a monitor
// on the falling edge pops and compares them.
module tb_exc_int_ctrl;

  logic clk;
  logic reset;

  exc_int_ctrl_if #(.N_IRQ(4)) bus ();

  exc_int_ctrl #(
    .N_IRQ      (4),
    .EXC_VECTOR (32'h80000008),
    .IRQ_BASE   (32'h80000010)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          idx;
    logic        red;
    logic [31:0] rpc;
    logic [31:0] epc;
    logic [3:0]  cause;
    logic        kern;
    logic [3:0]  pend;
    logic [3:0]  mask;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_no = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, want);
    end
  endtask

  // Monitor: compare whatever the driver queued for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("redirect",    e.idx, {31'd0, bus.redirect}, {31'd0, e.red});
      chk("redirect_pc", e.idx, bus.redirect_pc, e.rpc);
      chk("epc",         e.idx, bus.epc, e.epc);
      chk("cause",       e.idx, {28'd0, bus.cause}, {28'd0, e.cause});
      chk("kernel",      e.idx, {31'd0, bus.kernel}, {31'd0, e.kern});
      chk("pending",     e.idx, {28'd0, bus.pending}, {28'd0, e.pend});
      chk("mask",        e.idx, {28'd0, bus.mask}, {28'd0, e.mask});
    end
  end

  task automatic step(
    input logic rst_v, input logic [3:0] irq_v, input logic xpc, input logic xalu,
    input logic [31:0] pcc, input logic [31:0] pcn, input logic ert,
    input logic mwr, input logic [3:0] mwd,
    input logic e_red, input logic [31:0] e_rpc, input logic [31:0] e_epc,
    input logic [3:0] e_cause, input logic e_kern, input logic [3:0] e_pend,
    input logic [3:0] e_mask);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = rst_v;
    bus.irq        = irq_v;
    bus.exc_pc     = xpc;
    bus.exc_alu    = xalu;
    bus.pc_cur     = pcc;
    bus.pc_next    = pcn;
    bus.eret       = ert;
    bus.mask_wr    = mwr;
    bus.mask_wdata = mwd;
    e.idx   = step_no;
    e.red   = e_red;
    e.rpc   = e_rpc;
    e.epc   = e_epc;
    e.cause = e_cause;
    e.kern  = e_kern;
    e.pend  = e_pend;
    e.mask  = e_mask;
    exp_q.push_back(e);
    step_no++;
  endtask

  initial begin
    reset          = 1'b0;
    bus.irq        = 4'h0;
    bus.exc_pc     = 1'b0;
    bus.exc_alu    = 1'b0;
    bus.pc_cur     = 32'h0;
    bus.pc_next    = 32'h4;
    bus.eret       = 1'b0;
    bus.mask_wr    = 1'b0;
    bus.mask_wdata = 4'h0;

    //   rst irq  xpc xalu pc_cur        pc_next       eret mwr mwd  | red rpc           epc      cause kern pend mask
    // reset holds redirect low even with an exception strobe
    step(1'b0, 4'h0, 1'b0, 1'b1, 32'h0,   32'h4,        1'b0, 1'b0, 4'h0, 1'b0, 32'h4,        32'h0,   4'h0, 1'b0, 4'h0, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h4,        1'b0, 1'b0, 4'h0, 1'b0, 32'h4,        32'h0,   4'h0, 1'b0, 4'h0, 4'hF);
    // irq[1] rises, taken to IRQ_BASE+4, level held sets pending only once
    step(1'b1, 4'h2, 1'b0, 1'b0, 32'h0,   32'h100,      1'b0, 1'b0, 4'h0, 1'b0, 32'h100,      32'h0,   4'h0, 1'b0, 4'h0, 4'hF);
    step(1'b1, 4'h2, 1'b0, 1'b0, 32'h0,   32'h100,      1'b0, 1'b0, 4'h0, 1'b1, 32'h80000014, 32'h0,   4'h0, 1'b0, 4'h2, 4'hF);
    step(1'b1, 4'h2, 1'b0, 1'b0, 32'h0,   32'h104,      1'b0, 1'b0, 4'h0, 1'b0, 32'h104,      32'h100, 4'h9, 1'b1, 4'h0, 4'hF);
    // eret in KERNEL returns to epc, then eret in USER is ignored
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h4,        1'b1, 1'b0, 4'h0, 1'b1, 32'h100,      32'h100, 4'h9, 1'b1, 4'h0, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h4,        1'b0, 1'b0, 4'h0, 1'b0, 32'h4,        32'h100, 4'h0, 1'b0, 4'h0, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h4,        1'b1, 1'b0, 4'h0, 1'b0, 32'h4,        32'h100, 4'h0, 1'b0, 4'h0, 4'hF);
    // irq[0] and irq[2] together: 0 first, 2 after return
    step(1'b1, 4'h5, 1'b0, 1'b0, 32'h0,   32'h4,        1'b0, 1'b0, 4'h0, 1'b0, 32'h4,        32'h100, 4'h0, 1'b0, 4'h0, 4'hF);
    step(1'b1, 4'h5, 1'b0, 1'b0, 32'h0,   32'h200,      1'b0, 1'b0, 4'h0, 1'b1, 32'h80000010, 32'h100, 4'h0, 1'b0, 4'h5, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h300,      1'b0, 1'b0, 4'h0, 1'b0, 32'h300,      32'h200, 4'h8, 1'b1, 4'h4, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h4,        1'b1, 1'b0, 4'h0, 1'b1, 32'h200,      32'h200, 4'h8, 1'b1, 4'h4, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h210,      1'b0, 1'b0, 4'h0, 1'b1, 32'h80000018, 32'h200, 4'h0, 1'b0, 4'h4, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h220,      1'b0, 1'b0, 4'h0, 1'b0, 32'h220,      32'h210, 4'hA, 1'b1, 4'h0, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h4,        1'b1, 1'b0, 4'h0, 1'b1, 32'h210,      32'h210, 4'hA, 1'b1, 4'h0, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h4,        1'b0, 1'b0, 4'h0, 1'b0, 32'h4,        32'h210, 4'h0, 1'b0, 4'h0, 4'hF);
    // ALU overflow beats a pending interrupt; pending left alone
    step(1'b1, 4'h1, 1'b0, 1'b0, 32'h0,   32'h4,        1'b0, 1'b0, 4'h0, 1'b0, 32'h4,        32'h210, 4'h0, 1'b0, 4'h0, 4'hF);
    step(1'b1, 4'h1, 1'b0, 1'b1, 32'h40,  32'h4,        1'b0, 1'b0, 4'h0, 1'b1, 32'h80000008, 32'h210, 4'h0, 1'b0, 4'h1, 4'hF);
    step(1'b1, 4'h1, 1'b0, 1'b0, 32'h0,   32'h4,        1'b0, 1'b0, 4'h0, 1'b0, 32'h4,        32'h40,  4'h3, 1'b1, 4'h1, 4'hF);
    // nested PC overflow keeps epc, updates cause
    step(1'b1, 4'h1, 1'b1, 1'b0, 32'h0,   32'h4,        1'b0, 1'b0, 4'h0, 1'b1, 32'h80000008, 32'h40,  4'h3, 1'b1, 4'h1, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h4,        1'b1, 1'b0, 4'h0, 1'b1, 32'h40,       32'h40,  4'h2, 1'b1, 4'h1, 4'hF);
    // irq[0] taken while it rises again: set wins over clear
    step(1'b1, 4'h1, 1'b0, 1'b0, 32'h0,   32'h50,       1'b0, 1'b0, 4'h0, 1'b1, 32'h80000010, 32'h40,  4'h0, 1'b0, 4'h1, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h4,        1'b0, 1'b0, 4'h0, 1'b0, 32'h4,        32'h50,  4'h8, 1'b1, 4'h1, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h4,        1'b1, 1'b0, 4'h0, 1'b1, 32'h50,       32'h50,  4'h8, 1'b1, 4'h1, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h4,        1'b0, 1'b0, 4'h0, 1'b1, 32'h80000010, 32'h50,  4'h0, 1'b0, 4'h1, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h4,        1'b0, 1'b0, 4'h0, 1'b0, 32'h4,        32'h4,   4'h8, 1'b1, 4'h0, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h4,        1'b1, 1'b0, 4'h0, 1'b1, 32'h4,        32'h4,   4'h8, 1'b1, 4'h0, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h4,        1'b0, 1'b0, 4'h0, 1'b0, 32'h4,        32'h4,   4'h0, 1'b0, 4'h0, 4'hF);
    // illegal user -> kernel transition
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h200, 32'h80000100, 1'b0, 1'b0, 4'h0, 1'b1, 32'h80000008, 32'h4,   4'h0, 1'b0, 4'h0, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h4,        1'b0, 1'b0, 4'h0, 1'b0, 32'h4,        32'h200, 4'h1, 1'b1, 4'h0, 4'hF);
    // PC overflow outranks ALU overflow
    step(1'b1, 4'h0, 1'b1, 1'b1, 32'h0,   32'h4,        1'b0, 1'b0, 4'h0, 1'b1, 32'h80000008, 32'h200, 4'h1, 1'b1, 4'h0, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h4,        1'b1, 1'b0, 4'h0, 1'b1, 32'h200,      32'h200, 4'h2, 1'b1, 4'h0, 4'hF);
    // illegal outranks PC overflow
    step(1'b1, 4'h0, 1'b1, 1'b0, 32'h60,  32'h80000000, 1'b0, 1'b0, 4'h0, 1'b1, 32'h80000008, 32'h200, 4'h0, 1'b0, 4'h0, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h4,        1'b1, 1'b0, 4'h0, 1'b1, 32'h60,       32'h60,  4'h1, 1'b1, 4'h0, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h4,        1'b0, 1'b0, 4'h0, 1'b0, 32'h4,        32'h60,  4'h0, 1'b0, 4'h0, 4'hF);
    // masked irq[3] stays pending; mask write uses old mask that cycle
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h4,        1'b0, 1'b1, 4'h0, 1'b0, 32'h4,        32'h60,  4'h0, 1'b0, 4'h0, 4'hF);
    step(1'b1, 4'h8, 1'b0, 1'b0, 32'h0,   32'h4,        1'b0, 1'b0, 4'h0, 1'b0, 32'h4,        32'h60,  4'h0, 1'b0, 4'h0, 4'h0);
    step(1'b1, 4'h8, 1'b0, 1'b0, 32'h0,   32'h4,        1'b0, 1'b0, 4'h0, 1'b0, 32'h4,        32'h60,  4'h0, 1'b0, 4'h8, 4'h0);
    step(1'b1, 4'h8, 1'b0, 1'b0, 32'h0,   32'h4,        1'b0, 1'b1, 4'h8, 1'b0, 32'h4,        32'h60,  4'h0, 1'b0, 4'h8, 4'h0);
    step(1'b1, 4'h8, 1'b0, 1'b0, 32'h0,   32'h70,       1'b0, 1'b0, 4'h0, 1'b1, 32'h8000001C, 32'h60,  4'h0, 1'b0, 4'h8, 4'h8);
    step(1'b1, 4'h8, 1'b0, 1'b0, 32'h0,   32'h4,        1'b0, 1'b0, 4'h0, 1'b0, 32'h4,        32'h70,  4'hB, 1'b1, 4'h0, 4'h8);
    // asynchronous reset mid-handler, checked before the next rising edge
    step(1'b0, 4'h8, 1'b0, 1'b1, 32'h0,   32'h4,        1'b0, 1'b0, 4'h0, 1'b0, 32'h4,        32'h0,   4'h0, 1'b0, 4'h0, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h4,        1'b0, 1'b0, 4'h0, 1'b0, 32'h4,        32'h0,   4'h0, 1'b0, 4'h0, 4'hF);
    step(1'b1, 4'h0, 1'b0, 1'b0, 32'h0,   32'h4,        1'b0, 1'b0, 4'h0, 1'b0, 32'h4,        32'h0,   4'h0, 1'b0, 4'h0, 4'hF);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exc_int_ctrl.md
EXC_INT_CTRL -- requirements
Module: exc_int_ctrl

Interface
REQ-001 SHALL have parameter N_IRQ, default 4: number of interrupt sources, legal range 1..8.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'h80000008: handler address for all exceptions.
REQ-003 SHALL have parameter IRQ_BASE, default 32'h80000010: interrupt k vectors to IRQ_BASE + 4*k.
REQ-004 SHALL have port clk  input  1  the single processor clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port irq  input  N_IRQ  level interrupt requests (timer, UART, ...).
REQ-007 SHALL have port exc_pc, exc_alu  input  1 each  PC-overflow and ALU-overflow exception strobes.
REQ-008 SHALL have port pc_cur  input  32  PC of the instruction executing this cycle.
REQ-009 SHALL have port pc_next  input  32  PC the core would load next without redirection.
REQ-010 SHALL have port eret  input  1  current instruction is a return-from-handler.
REQ-011 SHALL have port mask_wr  input  1, mask_wdata  input  N_IRQ  mask register write.
REQ-012 SHALL have port redirect  output  1, redirect_pc  output  32  PC override for this cycle.
REQ-013 SHALL have port epc  output  32, cause  output  4, kernel  output  1, mask  output  N_IRQ, pending  output  N_IRQ.

Function
REQ-014 SHALL hold a two-state FSM, USER and KERNEL; kernel = (state==KERNEL).
REQ-015 SHALL register irq and set pending[k] on a 0->1 transition of irq[k]; a level held high sets it once.
REQ-016 SHALL define illegal = USER and pc_cur[31]==0 and pc_next[31]==1 (user code entering kernel space).
REQ-017 SHALL define take_exc = exc_pc | exc_alu | illegal, combinationally, in either state.
REQ-018 SHALL define take_irq = !take_exc and USER and |(pending & mask).
REQ-019 SHALL define take_ret = !take_exc and KERNEL and eret; eret in USER is ignored.
REQ-020 SHALL drive redirect = take_exc | take_irq | take_ret, combinationally, same cycle.
REQ-021 SHALL select redirect_pc: EXC_VECTOR on take_exc; IRQ_BASE+4*k for lowest-index k with pending&mask on take_irq; epc on take_ret; else pc_next.
REQ-022 SHALL encode cause: 1 illegal, 2 PC overflow, 3 ALU overflow, 8+k interrupt k; priority illegal > PC > ALU.
REQ-023 SHALL on take_exc in USER: epc <= pc_cur, cause <= code, state <= KERNEL.
REQ-024 SHALL on take_exc in KERNEL (nested): keep epc, cause <= code, stay KERNEL.
REQ-025 SHALL on take_irq: epc <= pc_next, cause <= 8+k, pending[k] <= 0, state <= KERNEL.
REQ-026 SHALL on take_ret: state <= USER, cause <= 0, epc unchanged.
REQ-027 SHALL, if irq[k] rises in the cycle pending[k] is cleared, leave pending[k]=1 (set wins).
REQ-028 SHALL on mask_wr load mask <= mask_wdata at the clock edge; take_irq in that cycle uses the old mask.
REQ-029 SHALL keep masked interrupts pending; they are taken once unmasked while USER.
REQ-030 SHALL ignore pending interrupts while KERNEL; no interrupt nesting.

Reset
REQ-031 SHALL on reset low, immediately and independent of clk: state=USER, epc=0, cause=0, mask=all ones, pending=0, irq history=0.
REQ-032 SHALL drive redirect=0 during reset regardless of inputs; reset mid-handler returns to USER and discards epc.

Verification
REQ-033 SHALL cover: irq[1] rises, mask=4'hF, USER, pc_next=0x100 -> redirect=1, redirect_pc=0x80000014, next cycle epc=0x100, cause=9, kernel=1, pending[1]=0.
REQ-034 SHALL cover: irq[0] and irq[2] rise together, USER -> irq 0 taken (redirect_pc 0x80000010); after eret, irq 2 taken (0x80000018, cause 10).
REQ-035 SHALL cover: exc_alu=1 with pending irq, pc_cur=0x40 -> redirect_pc=0x80000008, epc=0x40, cause=3, pending unchanged.
REQ-036 SHALL cover: USER, pc_cur=0x200, pc_next=0x80000100 -> redirect_pc=0x80000008, cause=1, epc=0x200.
REQ-037 SHALL cover: KERNEL, epc=0x100, eret=1 -> redirect_pc=0x100, next cycle kernel=0, cause=0; eret in USER -> redirect=0.
REQ-038 SHALL cover: mask=4'h0, irq[3] rises -> no redirect, pending=4'h8; mask_wr 4'h8 -> take next cycle; reset asserted in KERNEL -> all outputs at reset values before next clk edge.
